// File: rtl/iob_fifo2axis.sv
// Read-side drain stage for a synchronous FIFO: issues reads, absorbs the 1-cycle
// read latency in a 2-entry buffer and presents the words as an AXI-Stream master.
module iob_fifo2axis #(
    parameter int DATA_W = 21,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_n_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              fifo_r_en_o,
    input  logic [DATA_W-1:0] fifo_r_data_i,
    input  logic              fifo_r_empty_i,
    output logic [DATA_W-1:0] axis_tdata_o,
    output logic              axis_tvalid_o,
    input  logic              axis_tready_i,
    output logic              axis_tlast_o,
    output logic [LEN_W-1:0]  word_cnt_o
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [1:0]        held_q, held_d;
    logic              inflight_q;
    logic              rd_ptr_q, wr_ptr_q;
    logic [DATA_W-1:0] buf_q [2];
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic              pop;
    logic [1:0]        occ;

    assign pop = axis_tvalid_o & axis_tready_i;

    // Occupancy after this edge counting the word in flight; pop implies held_q >= 1,
    // so this cannot underflow, and reads stop at 2 so the buffer never overflows.
    assign occ = held_q + {1'b0, inflight_q} - {1'b0, pop};

    assign fifo_r_en_o = cke_i & arst_n_i & ~rst_i & en_i & ~fifo_r_empty_i & (occ < 2'd2);

    assign axis_tvalid_o = (held_q != 2'd0);
    assign axis_tdata_o  = buf_q[rd_ptr_q];
    assign axis_tlast_o  = (len_i != '0) & (word_cnt_q == len_i - LEN_ONE) & axis_tvalid_o;
    assign word_cnt_o    = word_cnt_q;

    always_comb begin
        held_d     = occ;
        word_cnt_d = word_cnt_q;
        if (pop) begin
            word_cnt_d = axis_tlast_o ? '0 : word_cnt_q + LEN_ONE;
        end
    end

    // NOTE: the buffer is reset as well, because tdata must read 0 out of reset;
    // a 2-entry register file costs nothing extra to clear.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            held_q     <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            word_cnt_q <= '0;
        end else if (cke_i) begin
            if (rst_i) begin
                held_q     <= '0;
                inflight_q <= 1'b0;
                rd_ptr_q   <= 1'b0;
                wr_ptr_q   <= 1'b0;
                buf_q[0]   <= '0;
                buf_q[1]   <= '0;
                word_cnt_q <= '0;
            end else begin
                // NOTE: non-blocking assignments everywhere here so every register
                // samples the pre-edge values of the others.
                held_q     <= held_d;
                inflight_q <= fifo_r_en_o;
                word_cnt_q <= word_cnt_d;
                if (inflight_q) begin
                    buf_q[wr_ptr_q] <= fifo_r_data_i;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

endmodule
